// File: rtl/cluster_pkg.sv
// Shared constants and types for the SHM read copy engine.
// Word/address widths, bus strobe values, FSM states, pipe tag.
package cluster_pkg;
  localparam int SIZE      = 16;
  localparam int WORD_SIZE = 32;
  localparam int PROCSIZE  = 16;
  localparam int PAGE_SIZE = 256;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {
    SCAN,
    ISSUE,
    DRAIN,
    DONE
  } shm_rd_state_t;

  typedef struct packed {
    logic                vld;
    logic [PROCSIZE-1:0] dst;
  } rd_tag_t;
endpackage

// File: rtl/shm_reader_if.sv
// Bus bundle of shm_reader: per-processor request/ack/local-mem
// signals plus the SHM read port. master = engine, slave = env.
interface shm_reader_if
  import cluster_pkg::*;
#(
  parameter int PROC_CNT = 4
) ();
  localparam int CW = $clog2(PROC_CNT);

  logic [PROC_CNT-1:0]                trigger;
  logic [PROC_CNT-1:0]                ack;
  logic [PROC_CNT-1:0][SIZE-1:0]      ptr;
  logic [PROC_CNT-1:0][PROCSIZE-1:0]  copy_start;
  logic [PROC_CNT-1:0][PROCSIZE-1:0]  copy_length;
  logic [PROC_CNT-1:0][PROCSIZE-1:0]  proc_mem_addr;
  logic [PROC_CNT-1:0][WORD_SIZE-1:0] proc_mem_data_in;
  logic [PROC_CNT-1:0]                proc_mem_rw;
  logic [SIZE-1:0]                    shm_addr;
  logic                               shm_rd_en;
  logic [WORD_SIZE-1:0]               shm_data;
  logic                               busy;
  logic [CW-1:0]                      current_proc;

  modport master (
    input  trigger, ptr, copy_start, copy_length, shm_data,
    output ack, proc_mem_addr, proc_mem_data_in, proc_mem_rw,
    output shm_addr, shm_rd_en, busy, current_proc
  );

  modport slave (
    output trigger, ptr, copy_start, copy_length, shm_data,
    input  ack, proc_mem_addr, proc_mem_data_in, proc_mem_rw,
    input  shm_addr, shm_rd_en, busy, current_proc
  );
endinterface

// File: rtl/shm_rd_pipe.sv
// RD_LAT-deep delay line of {valid, dest addr} matching SHM read latency.
// Ports: clock, reset_n, i_push, i_dst -> o_head, o_empty.
module shm_rd_pipe
  import cluster_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_push,
  input  logic [PROCSIZE-1:0] i_dst,
  output rd_tag_t             o_head,
  output logic                o_empty
);
  rd_tag_t r_stg [RD_LAT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) r_stg[i] <= '0;
    end else begin
      r_stg[0] <= '{vld: i_push, dst: i_dst};
      for (int i = 1; i < RD_LAT; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  assign o_head = r_stg[RD_LAT-1];

  // Empty once the head retires: nothing queued behind it.
  always_comb begin
    o_empty = 1'b1;
    for (int i = 0; i < RD_LAT - 1; i++)
      if (r_stg[i].vld) o_empty = 1'b0;
  end
endmodule

// File: rtl/shm_reader.sv
// Round-robin SHM-to-local-memory copy engine with toggle handshake.
// Ports: clock, reset_n, bus (shm_reader_if.master).
module shm_reader
  import cluster_pkg::*;
#(
  parameter int PROC_CNT = 4,
  parameter int RD_LAT   = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  shm_reader_if.master  bus
);
  localparam int CW = $clog2(PROC_CNT);

  shm_rd_state_t       r_state;
  shm_rd_state_t       w_nxt;
  logic [CW-1:0]       r_cur;
  logic [PROC_CNT-1:0] r_last;
  logic [PROC_CNT-1:0] r_ack;
  logic [SIZE-1:0]     r_ptr;
  logic [PROCSIZE-1:0] r_start;
  logic [PROCSIZE-1:0] r_len;
  logic [PROCSIZE-1:0] r_idx;

  logic                w_pend;
  logic                w_issue;
  logic                w_last_iss;
  logic                w_empty;
  logic [CW-1:0]       w_cur_inc;
  logic [PROCSIZE-1:0] w_dst;
  rd_tag_t             w_head;

  assign w_pend     = bus.trigger[r_cur] ^ r_last[r_cur];
  assign w_issue    = (r_state == ISSUE);
  assign w_last_iss = (r_idx == r_len - PROCSIZE'(1));
  assign w_cur_inc  = (r_cur == CW'(PROC_CNT - 1))
                    ? '0 : r_cur + CW'(1);
  assign w_dst      = r_start + r_idx;

  shm_rd_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_issue),
    .i_dst   (w_dst),
    .o_head  (w_head),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= SCAN;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      SCAN:
        if (w_pend)
          w_nxt = (bus.copy_length[r_cur] == '0) ? DONE : ISSUE;
      ISSUE:   if (w_last_iss) w_nxt = DRAIN;
      DRAIN:   if (w_empty) w_nxt = DONE;
      DONE:    w_nxt = SCAN;
      default: w_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cur   <= '0;
      r_last  <= '0;
      r_ack   <= '0;
      r_ptr   <= '0;
      r_start <= '0;
      r_len   <= '0;
      r_idx   <= '0;
    end else begin
      if (r_state == SCAN) begin
        if (w_pend) begin
          r_ptr         <= bus.ptr[r_cur];
          r_start       <= bus.copy_start[r_cur];
          r_len         <= bus.copy_length[r_cur];
          r_idx         <= '0;
          r_last[r_cur] <= bus.trigger[r_cur];
        end else begin
          r_cur <= w_cur_inc;
        end
      end
      if (w_issue) r_idx <= r_idx + PROCSIZE'(1);
      if (r_state == DONE) begin
        r_ack[r_cur] <= ~r_ack[r_cur];
        r_cur        <= w_cur_inc;
      end
    end
  end

  always_comb begin
    bus.ack              = r_ack;
    bus.busy             = (r_state != SCAN);
    bus.current_proc     = r_cur;
    bus.shm_rd_en        = w_issue;
    bus.shm_addr         = w_issue ? r_ptr + SIZE'(r_idx) : '0;
    bus.proc_mem_rw      = '0;
    bus.proc_mem_addr    = '0;
    bus.proc_mem_data_in = '0;
    // SHM q arrives together with its tag at the pipe head.
    if (w_head.vld) begin
      bus.proc_mem_rw[r_cur]      = WRITE;
      bus.proc_mem_addr[r_cur]    = w_head.dst;
      bus.proc_mem_data_in[r_cur] = bus.shm_data;
    end
  end
endmodule

// File: tb/tb_shm_reader.sv
// Scoreboard bench for shm_reader: random copy requests vs a queue model.
// Drives on negedge, monitor samples 1 time unit after posedge.
`timescale 1ns/1ps
module tb_shm_reader;
  import cluster_pkg::*;

  localparam int P  = 4;
  localparam int RL = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  shm_reader_if #(.PROC_CNT(P)) bus ();

  shm_reader #(.PROC_CNT(P), .RD_LAT(RL)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // SHM content store: registered address, registered q.
  logic [WORD_SIZE-1:0] mem [65536];
  logic [SIZE-1:0]      m_a;
  logic [WORD_SIZE-1:0] m_q;
  always @(posedge clock) begin
    m_a <= bus.shm_addr;
    m_q <= mem[m_a];
  end
  assign bus.shm_data = m_q;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_total = 0;
  int start_cyc = 0;
  int start_p = 0;
  int mp;
  logic prev_busy = 1'b0;
  logic [P-1:0] prev_ack = '0;

  logic [SIZE-1:0]      exp_rd [P][$];
  logic [PROCSIZE-1:0]  exp_wa [P][$];
  logic [WORD_SIZE-1:0] exp_wd [P][$];
  int                   exp_len [P][$];
  int                   ack_order [$];

  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_evt(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event expected none", nm);
  endfunction

  function automatic int lat_of(int len);
    return (len == 0) ? 1 : len + RL + 1;
  endfunction

  function automatic int outstanding();
    int n = 0;
    for (int p = 0; p < P; p++) n += exp_len[p].size();
    return n;
  endfunction

  function automatic int leftover();
    int n = 0;
    for (int p = 0; p < P; p++)
      n += exp_rd[p].size() + exp_wa[p].size();
    return n;
  endfunction

  function automatic void flush();
    for (int p = 0; p < P; p++) begin
      exp_rd[p].delete();
      exp_wa[p].delete();
      exp_wd[p].delete();
      exp_len[p].delete();
    end
  endfunction

  // Monitor: busy rise marks cycle after accept; ack toggle closes it.
  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      prev_busy = 1'b0;
      prev_ack  = '0;
    end else begin
      cyc++;
      if (bus.shm_rd_en) begin
        mp = int'(bus.current_proc);
        if (exp_rd[mp].size() == 0) fail_evt("rd_unexpected");
        else chk("rd_addr", longint'(bus.shm_addr),
                 longint'(exp_rd[mp].pop_front()));
      end
      for (int p = 0; p < P; p++) begin
        if (bus.proc_mem_rw[p]) begin
          if (exp_wa[p].size() == 0) fail_evt("wr_unexpected");
          else begin
            chk("wr_addr", longint'(bus.proc_mem_addr[p]),
                longint'(exp_wa[p].pop_front()));
            chk("wr_data", longint'(bus.proc_mem_data_in[p]),
                longint'(exp_wd[p].pop_front()));
            wr_total++;
          end
        end
      end
      for (int p = 0; p < P; p++) begin
        if (bus.ack[p] != prev_ack[p]) begin
          if (exp_len[p].size() == 0) fail_evt("ack_unexpected");
          else begin
            chk("ack_latency", longint'(cyc - start_cyc),
                longint'(lat_of(exp_len[p].pop_front())));
            chk("ack_proc", longint'(p), longint'(start_p));
          end
          ack_order.push_back(p);
        end
      end
      if (bus.busy && !prev_busy) begin
        start_cyc = cyc;
        start_p   = int'(bus.current_proc);
      end
      prev_busy = bus.busy;
      prev_ack  = bus.ack;
    end
  end

  task automatic req(int p, logic [SIZE-1:0] pt,
                     logic [PROCSIZE-1:0] st, int len);
    logic [SIZE-1:0] a;
    bus.ptr[p]         = pt;
    bus.copy_start[p]  = st;
    bus.copy_length[p] = PROCSIZE'(len);
    for (int i = 0; i < len; i++) begin
      a = pt + SIZE'(i);
      exp_rd[p].push_back(a);
      exp_wa[p].push_back(st + PROCSIZE'(i));
      exp_wd[p].push_back(mem[a]);
    end
    exp_len[p].push_back(len);
    bus.trigger[p] = ~bus.trigger[p];
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while ((outstanding() != 0 || bus.busy) && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (outstanding() != 0 || bus.busy) fail_evt("idle_timeout");
    chk("leftover", longint'(leftover()), 0);
  endtask

  task automatic chk_zero(string t);
    chk({t, "_busy"}, longint'(bus.busy), 0);
    chk({t, "_rd_en"}, longint'(bus.shm_rd_en), 0);
    chk({t, "_shm_addr"}, longint'(bus.shm_addr), 0);
    chk({t, "_ack"}, longint'(bus.ack), 0);
    chk({t, "_rw"}, longint'(bus.proc_mem_rw), 0);
    chk({t, "_cur"}, longint'(bus.current_proc), 0);
    chk({t, "_maddr"}, longint'(bus.proc_mem_addr), 0);
    chk({t, "_mdata"}, longint'(|bus.proc_mem_data_in), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int n0;
    logic [P-1:0] m;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    bus.trigger     = '0;
    bus.ptr         = '0;
    bus.copy_start  = '0;
    bus.copy_length = '0;
    repeat (3) @(negedge clock);
    chk_zero("reset");
    reset_n = 1'b1;

    // Basic 4-word copy on proc 1.
    @(negedge clock);
    req(1, 16'h0100, 16'h0020, 4);
    wait_idle(100);

    // Zero length on proc 0.
    @(negedge clock);
    req(0, 16'h1234, 16'h0040, 0);
    wait_idle(100);

    // All triggers at once while the scan sits on proc 2.
    k = 0;
    while (bus.current_proc != 2'd2 && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("t3_start_cur", longint'(bus.current_proc), 2);
    ack_order.delete();
    for (int p = 0; p < P; p++)
      req(p, SIZE'($urandom), PROCSIZE'($urandom),
          int'($urandom_range(1, 5)));
    wait_idle(300);
    chk("t3_n_acks", longint'(ack_order.size()), 4);
    for (int i = 0; i < ack_order.size() && i < 4; i++)
      chk("t3_order", longint'(ack_order[i]), longint'((2 + i) % 4));

    // Address wrap on both sides.
    @(negedge clock);
    req(3, 16'hFFFE, 16'hFFFF, 4);
    wait_idle(100);

    // Inputs changed mid-transfer are ignored.
    @(negedge clock);
    req(2, SIZE'($urandom), PROCSIZE'($urandom), 6);
    k = 0;
    while (!(bus.busy && bus.current_proc == 2'd2) && k < 20) begin
      @(negedge clock);
      k++;
    end
    @(negedge clock);
    bus.ptr[2]         = SIZE'($urandom);
    bus.copy_start[2]  = PROCSIZE'($urandom);
    bus.copy_length[2] = PROCSIZE'($urandom_range(1, 9));
    wait_idle(100);

    // Randomized rounds.
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clock);
      m = P'($urandom_range(1, 15));
      for (int p = 0; p < P; p++)
        if (m[p])
          req(p, SIZE'($urandom), PROCSIZE'($urandom),
              int'($urandom_range(0, 6)));
      wait_idle(400);
      for (int p = 0; p < P; p++) begin
        bus.ptr[p]         = SIZE'($urandom);
        bus.copy_length[p] = PROCSIZE'($urandom);
      end
    end

    // Reset in the middle of ISSUE after two writes.
    @(negedge clock);
    n0 = ack_order.size();
    k  = wr_total;
    req(2, SIZE'($urandom), PROCSIZE'($urandom), 8);
    while (wr_total < k + 2 && k > -1 && wr_total < k + 100) begin
      @(negedge clock);
      if (cyc > 100000) break;
    end
    reset_n     = 1'b0;
    bus.trigger = '0;
    #1;
    chk_zero("mid_reset");
    chk("t6_no_ack", longint'(ack_order.size()), longint'(n0));
    chk("t6_two_writes", longint'(wr_total - k), 2);
    flush();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    req(0, SIZE'($urandom), PROCSIZE'($urandom), 3);
    @(negedge clock);
    chk("t6_accept_p0", longint'(bus.busy), 1);
    chk("t6_cur_p0", longint'(bus.current_proc), 0);
    wait_idle(100);

    repeat (5) @(negedge clock);
    chk("final_outstanding", longint'(outstanding()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
